// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan driver: FSM encoding,
// display geometry and the active-low hex glyph table.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int VAL_W      = 9;
    localparam int BCD_W      = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

endpackage

// File: rtl/ssd_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// VAL_W iterations per conversion, restarted by start.
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [VAL_W-1:0] shreg;
    logic [3:0]       iter;
    logic             busy;
    logic [BCD_W-1:0] adj;

    // NOTE: every bit gets a default before the conditional updates, so no latch is inferred.
    always_comb begin
        adj = bcd;
        for (int n = 0; n < BCD_W / 4; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end
        end
    end

    // High during the final iteration; bcd holds the full result from the next cycle on.
    assign done = busy && (iter == 4'(VAL_W - 1));

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            iter  <= '0;
            busy  <= 1'b0;
            bcd   <= '0;
        end else if (start) begin
            shreg <= bin;
            iter  <= '0;
            busy  <= 1'b1;
            bcd   <= '0;
        end else if (busy) begin
            bcd   <= {adj[BCD_W-2:0], shreg[VAL_W-1]};
            shreg <= shreg << 1;
            iter  <= iter + 4'd1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// 4-digit common-anode scan driver: samples {carry,sum}, formats it as hex or
// decimal with leading-zero blanking, and time-multiplexes the digits.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] value,
    input  logic             dec_mode,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [3:0]       an
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t                     state;
    logic [VAL_W-1:0]           samp_val;
    logic                       samp_dec;
    logic                       pending;
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [PW-1:0]              presc;
    logic [1:0]                 idx;
    logic                       changed;
    logic                       conv_start;
    logic                       conv_done;
    logic [BCD_W-1:0]           bcd;
    logic [NUM_DIGITS-1:0]      blank;
    logic                       upper_zero;

    assign changed    = pending || (value != samp_val) || (dec_mode != samp_dec);
    assign conv_start = (state == S_IDLE) && changed && dec_mode;
    assign dp         = 1'b1;

    // The converter loads the live input in the same cycle the sample register does.
    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (value),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            samp_val <= '0;
            samp_dec <= 1'b0;
            pending  <= 1'b1;
            digits   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (changed) begin
                        samp_val <= value;
                        samp_dec <= dec_mode;
                        pending  <= 1'b0;
                        state    <= dec_mode ? S_CONV : S_COMMIT;
                    end
                end
                S_CONV: begin
                    if (conv_done) begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // All four digits swap in one edge so a scan never sees a half-updated value.
                    digits <= samp_dec ? {4'd0, bcd}
                                       : {4'd0, 3'd0, samp_val[8], samp_val[7:4], samp_val[3:0]};
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A digit is blank when it and every digit to its left are zero; digit 0 always shows.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (digits[k] == 4'd0);
            blank[k]   = upper_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            an    <= 4'b1111;
            seg   <= SEG_BLANK;
        end else begin
            if (presc == PW'(REFRESH_DIV - 1)) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            an  <= ~(4'b0001 << idx);
            seg <= blank[idx] ? SEG_BLANK : hex_to_seg(digits[idx]);
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: a time-based reference model predicts
// An/Seg every cycle, plus literal glyph checks for the named display scenarios.
module tb_ssd_scan_driver;

    localparam int R = 4;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] value = 9'd0;
    logic       dec_mode = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_checks = 0;
    int n_fail   = 0;

    ssd_scan_driver #(.REFRESH_DIV(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .dec_mode (dec_mode),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Reference model: edges counted since reset release decide capture, commit and scan position.
    int         e = 0;
    int         next_idle = 1;
    int         commit_edge = 0;
    bit         commit_due = 0;
    bit         m_pend = 1;
    logic [8:0] m_sv = '0;
    logic       m_sd = 1'b0;
    logic [3:0] m_dig [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] m_new [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    int         m_idx = 0;
    logic [3:0] exp_an = 4'b1111;
    logic [6:0] exp_seg = BLANK;

    function automatic logic [6:0] expected_glyph(input int k);
        bit lead = 1'b1;
        for (int j = 3; j >= k; j--) if (m_dig[j] != 4'd0) lead = 1'b0;
        return (k > 0 && lead) ? BLANK : GLYPH[m_dig[k]];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            e = 0; next_idle = 1; commit_due = 0; m_pend = 1;
            m_sv = '0; m_sd = 1'b0; m_idx = 0;
            for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
            exp_an = 4'b1111; exp_seg = BLANK;
        end else begin
            e++;
            exp_an  = ~(4'b0001 << m_idx);
            exp_seg = expected_glyph(m_idx);
            if (commit_due && e == commit_edge) begin
                m_dig = m_new;
                commit_due = 0;
            end
            if (e >= next_idle && (m_pend || value != m_sv || dec_mode != m_sd)) begin
                m_sv = value; m_sd = dec_mode; m_pend = 0;
                if (dec_mode) begin
                    m_new[0] = 4'(value % 10); m_new[1] = 4'((value / 10) % 10);
                    m_new[2] = 4'(value / 100);
                end else begin
                    m_new[0] = 4'(value % 16); m_new[1] = 4'((value / 16) % 16);
                    m_new[2] = 4'(value / 256);
                end
                m_new[3] = 4'd0;
                commit_edge = e + (dec_mode ? 10 : 1);
                next_idle   = commit_edge + 1;
                commit_due  = 1;
            end
            m_idx = (e / R) % 4;
        end
    end

    task automatic test_reset();
        logic [6:0] want;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        n_checks++;
        if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_immediate: an=%b seg=%b dp=%b, required an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (11) @(posedge clk);
        repeat (4 * R) begin
            @(posedge clk); #2;
            want = (an == 4'b1110) ? 7'b1000000 : BLANK;
            n_checks++;
            if (seg !== want || an !== exp_an || dp !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_zero_display: an=%b seg=%b dp=%b, required an=%b seg=%b dp=1", an, seg, dp, exp_an, want);
            end
        end
    endtask

    task automatic test_hex();
        logic [6:0] want [4];
        int k;
        want[0] = 7'b0010010; want[1] = 7'b0001000; want[2] = 7'b1111001; want[3] = BLANK;
        @(negedge clk) begin value = 9'd421; dec_mode = 1'b0; end
        repeat (3) begin
            @(posedge clk); #2;
            n_checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL hex_latency: an=%b seg=%b, required an=%b seg=%b", an, seg, exp_an, exp_seg);
            end
        end
        repeat (4 * R) begin
            @(posedge clk); #2;
            k = -1;
            for (int j = 0; j < 4; j++) if (an == ~(4'b0001 << j)) k = j;
            n_checks++;
            if (k < 0 || seg !== want[k]) begin
                n_fail++;
                $display("FAIL hex_1A5: an=%b seg=%b, required glyph for digit %0d", an, seg, k);
            end
        end
    endtask

    task automatic test_decimal();
        logic [8:0] vals [3];
        logic [6:0] want [3][4];
        int k;
        vals[0] = 9'd421; vals[1] = 9'd511; vals[2] = 9'd9;
        want[0] = '{7'b1111001, 7'b0100100, 7'b0011001, BLANK};
        want[1] = '{7'b1111001, 7'b1111001, 7'b0010010, BLANK};
        want[2] = '{7'b0010000, BLANK, BLANK, BLANK};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk) begin value = vals[t]; dec_mode = 1'b1; end
            repeat (13) begin
                @(posedge clk); #2;
                n_checks++;
                if (an !== exp_an || seg !== exp_seg) begin
                    n_fail++;
                    $display("FAIL dec_latency_%0d: an=%b seg=%b, required an=%b seg=%b", vals[t], an, seg, exp_an, exp_seg);
                end
            end
            repeat (4 * R) begin
                @(posedge clk); #2;
                k = -1;
                for (int j = 0; j < 4; j++) if (an == ~(4'b0001 << j)) k = j;
                n_checks++;
                if (k < 0 || seg !== want[t][k]) begin
                    n_fail++;
                    $display("FAIL dec_digits_%0d: an=%b seg=%b, required glyph for digit %0d", vals[t], an, seg, k);
                end
            end
        end
    endtask

    task automatic test_mid_conversion();
        logic [6:0] want [4];
        int k;
        want[0] = 7'b1000000; want[1] = 7'b1000000; want[2] = 7'b0100100; want[3] = BLANK;
        @(negedge clk) begin value = 9'd100; dec_mode = 1'b1; end
        repeat (4) begin
            @(posedge clk); #2;
            n_checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL midconv_pre: an=%b seg=%b, required an=%b seg=%b", an, seg, exp_an, exp_seg);
            end
        end
        @(negedge clk) value = 9'd200;
        repeat (26) begin
            @(posedge clk); #2;
            n_checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL midconv_track: an=%b seg=%b, required an=%b seg=%b", an, seg, exp_an, exp_seg);
            end
        end
        repeat (4 * R) begin
            @(posedge clk); #2;
            k = -1;
            for (int j = 0; j < 4; j++) if (an == ~(4'b0001 << j)) k = j;
            n_checks++;
            if (k < 0 || seg !== want[k]) begin
                n_fail++;
                $display("FAIL midconv_200: an=%b seg=%b, required glyph for digit %0d", an, seg, k);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] prev;
        int run;
        bit first;
        @(posedge clk); #2;
        prev = an; run = 1; first = 1'b1;
        repeat (12 * R) begin
            @(posedge clk); #2;
            if (an === prev) begin
                run++;
            end else begin
                n_checks++;
                if (an !== {prev[2:0], prev[3]}) begin
                    n_fail++;
                    $display("FAIL scan_order: an=%b after %b, required %b", an, prev, {prev[2:0], prev[3]});
                end
                if (!first) begin
                    n_checks++;
                    if (run != R) begin
                        n_fail++;
                        $display("FAIL scan_dwell: an=%b held %0d cycles, required %0d", prev, run, R);
                    end
                end
                first = 1'b0; run = 1; prev = an;
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk) begin
                value    = 9'($urandom_range(0, 511));
                dec_mode = 1'($urandom_range(0, 1));
            end
            hold = $urandom_range(1, 25);
            repeat (hold) begin
                @(posedge clk); #2;
                n_checks++;
                if (an !== exp_an || seg !== exp_seg) begin
                    n_fail++;
                    $display("FAIL random_%0d: value=%0d dec=%b an=%b seg=%b, required an=%b seg=%b",
                             t, value, dec_mode, an, seg, exp_an, exp_seg);
                end
            end
        end
        repeat (30) begin
            @(posedge clk); #2;
            n_checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL random_settle: an=%b seg=%b, required an=%b seg=%b", an, seg, exp_an, exp_seg);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_hex();
        test_decimal();
        test_mid_conversion();
        test_scan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Sequential display back-end that consumes the 9-bit arithmetic result ({carry, 8-bit sum}) and drives a 4-digit, common-anode, time-multiplexed seven-segment display. It shows the value in hexadecimal or in decimal; decimal digits come from an on-block multi-cycle binary-to-BCD converter. Leading zeros are blanked, and the digit scan is paced by a prescaler. The block sits directly downstream of the adder/comparator datapath and replaces the static single-digit segment output.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range 2..2^20.
- Clk  in  1  system clock.
- Rst  in  1  asynchronous, active-high reset.
- Value  in  9  unsigned result to display, {Cout, Sum}, range 0..511.
- DecMode  in  1  display format: 1 = decimal, 0 = hexadecimal.
- Seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- Dp  out  1  decimal point, active-low; held at 1 (off).
- An  out  4  digit anodes, active-low, one-hot; An[0] is the rightmost digit.

## Operation
- Sample register holds SampVal (9 bits) and SampDec (1 bit). A pending flag is set by reset.
- **IDLE**
  - If pending is set, or Value ≠ SampVal, or DecMode ≠ SampDec: capture both inputs, clear pending.
  - Then go to CONV if DecMode = 1, otherwise to COMMIT.
- **CONV** (double-dabble)
  - 9 iterations, one per clock.
  - Each iteration: add 3 to any BCD nibble ≥ 5, then shift left one bit, bringing in the next MSB of SampVal.
  - BCD scratch register is 12 bits (3 nibbles), because the maximum value is 511.
  - Iteration counter is 4 bits. Go to COMMIT after iteration 9.
- **COMMIT**
  - Load the digit register D3..D0 in one cycle, so the display never shows a partial result.
  - Decimal: D3 = 0, D2..D0 = the BCD nibbles.
  - Hex: D3 = 0, D2 = {000, SampVal[8]}, D1 = SampVal[7:4], D0 = SampVal[3:0].
  - Return to IDLE.
- **Blanking**
  - Digit k is blanked (Seg = 7'b1111111) when Dk and all higher digits are zero, for k ≥ 1.
  - D0 is always shown.
- **Segment encoding**, hex glyphs 0–F, active-low. Examples:
  - 0 = 7'b1000000, 1 = 7'b1111001, 4 = 7'b0011001, 5 = 7'b0010010
  - 2 = 7'b0100100, A = 7'b0001000, F = 7'b0001110
- **Scan**
  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - At the terminal count the 2-bit digit index advances 0→1→2→3→0.
  - An = ~(1 << index). Seg shows the glyph (or blank) for digit[index].
- **Changes during conversion**
  - Value and DecMode changes while in CONV or COMMIT are ignored by the conversion in progress.
  - The next IDLE cycle compares against the sample; the latest value always wins, with no queueing.

## Timing
- Reset, held while Rst = 1 and effective immediately:
  - An = 4'b1111, Seg = 7'b1111111, Dp = 1.
  - Digit register = 0, prescaler = 0, index = 0, state = IDLE, pending = 1.
- First cycle after reset release: pending forces a capture, so "0" is displayed once the conversion commits.
- Latency from input change to digit register update:
  - Decimal: 11 cycles (1 sample + 9 CONV + 1 COMMIT).
  - Hex: 2 cycles (1 sample + 1 COMMIT).
- Seg and An are registered. They change 1 cycle after the index change or digit register update.
- Each digit is active for exactly REFRESH_DIV cycles. The full frame is 4·REFRESH_DIV cycles.
- An input change in the same cycle as COMMIT is not lost: it is detected on the following IDLE cycle.
- Rst asserted mid-conversion aborts it. Partial BCD results are never committed.

## Structure
- Package ssd_pkg holds:
  - the state encoding (IDLE, CONV, COMMIT)
  - NUM_DIGITS = 4 and the 9-bit value width
  - the hex-to-segment glyph constants and the blank constant
- Sub-module bin2bcd_seq holds the CONV datapath and its iteration counter:
  - inputs: start, 9-bit bin
  - outputs: done, 12-bit bcd
- The top level contains:
  - the sample/compare logic and the commit logic
  - blanking
  - the prescaler, the digit index and the output registers

## Test plan
- Reset: assert Rst mid-frame → An = 1111, Seg = 1111111, Dp = 1 the same cycle. After release and 11 cycles, only An[0] shows Seg = 1000000 ("0"); digits 1–3 are blank.
- Hex 0x1A5: Value = 421, DecMode = 0, REFRESH_DIV = 4 → within 2 cycles digits read "1A5".
  - Index 2 gives Seg = 1111001, index 1 gives 0001000, index 0 gives 0010010, index 3 is blank.
- Decimal 421: DecMode = 1 → digits update exactly 11 cycles after the change and read "421" (0011001, 0100100, 1111001).
- Decimal 511 (maximum) → "511". Value = 9 → only digit 0 lit ("9"); digits 1–2 blanked.
- Mid-conversion change: Value = 100 → 200 at CONV iteration 4.
  - "100" is committed first.
  - "200" is committed 11 cycles after that commit.
  - No mixed digits ever appear.
- Scan: REFRESH_DIV = 4 → An sequence 1110, 1101, 1011, 0111, each held exactly 4 cycles, with wrap back to 1110.
